regfile_wb_arbiter: RTL
=======================

# regfile_wb_arbiter

Write-back arbiter and scoreboard for the 32×32 register file. It lets two write-back requesters share the file's single write port: requester 0 is the single-cycle ALU path and requester 1 is the multi-cycle load/mul-div path. Grants are round-robin, and the winning write is driven through one registered stage onto the file's `we`/`writeRegister`/`writeData` inputs. A pending-write scoreboard is kept so the issue stage can stall on RAW hazards.

## Interface
Parameters:
- `DATA_W`, 32, width of write data.
- `ADDR_W`, 5, register index width.
- `NUM_REGS`, 32, scoreboard depth; equals 2^`ADDR_W`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req0_valid`  in  1  ALU write-back request.
- `req0_rd`  in  `ADDR_W`  destination register for requester 0.
- `req0_data`  in  `DATA_W`  write data for requester 0.
- `req0_ready`  out  1  grant to requester 0; the transfer occurs when valid && ready.
- `req1_valid`, `req1_rd`, `req1_data`, `req1_ready`: same as requester 0, for the load/mul-div requester.
- `issue_valid`  in  1  an instruction with a destination register issues this cycle.
- `issue_rd`  in  `ADDR_W`  destination register of the issuing instruction.
- `sb_pending`  out  `NUM_REGS`  scoreboard; bit i=1 means a write to register i is outstanding.
- `rf_we`  out  1  drives the register file `we`.
- `rf_waddr`  out  `ADDR_W`  drives `writeRegister`.
- `rf_wdata`  out  `DATA_W`  drives `writeData`.

## Operation
- **Output stage.** The output stage always drains, because the register file accepts a write every cycle. `reqN_ready` is therefore purely the combinational arbitration grant; there is no backpressure other than losing arbitration.
- **Arbitration.** This is 2-way round-robin with a 1-bit `last_grant` register.
  - One valid requester: it is granted.
  - Both valid: the requester that was not `last_grant` is granted.
  - `last_grant` updates only on an actual grant.
  - At most one ready is high per cycle.
- **Register x0.** A granted transfer with rd=0 is accepted (ready=1) but produces `rf_we`=0. The scoreboard is untouched.
- **Output register.** On a grant, `rf_we`/`rf_waddr`/`rf_wdata` are loaded with 1/rd/data on the next edge. With no grant, `rf_we` loads 0 and address/data hold their values.
- **Scoreboard set.** `issue_valid` with `issue_rd`≠0 sets bit `issue_rd`.
- **Scoreboard clear.** The bit is cleared when the output stage retires a write to that register (`rf_we`=1, bit `rf_waddr`) on the edge at which the file is written.
- **Simultaneous set and clear on one index.** Set wins, because a newer producer is now pending.
- **x0.** `sb_pending[0]` is constant 0.
- **Contract violations.** Requesters must not present a write whose scoreboard bit is clear. This is not checked in RTL and is an assertion only.
- **Reset (rst low, asynchronous).**
  - `rf_we`=0, `rf_waddr`=0, `rf_wdata`=0.
  - `sb_pending`=0.
  - `last_grant`=1, so requester 0 wins the first tie.
  - An accepted but un-retired write in the output stage is discarded.
  - Ready outputs are combinational: 0 while no request is valid.

## Timing
- Grant is combinational, in the same cycle as valid.
- Accept in cycle N → `rf_we` high in cycle N+1 → register file updated at the end of N+1. Total latency is 1 cycle to port, 2 edges to architectural state.
- A scoreboard bit set at edge E is visible on `sb_pending` after E. A bit is cleared at the edge where the register file is written.
- Throughput is one write per cycle in aggregate. Under continuous contention each requester gets every other cycle.

## Configuration
- `RF_ARB_BYPASS_EN` defined:
  - Adds inputs `rs1_addr`, `rs2_addr` (`ADDR_W`).
  - Adds outputs `fwd1_hit`, `fwd1_data`, `fwd2_hit`, `fwd2_data`.
  - `fwdK_hit` = `rf_we` && `rf_waddr`==`rsK_addr` && `rsK_addr`≠0, combinational.
  - `fwdK_data` = `rf_wdata`.
  - This covers the read-during-write cycle, in which the file's combinational read still returns old data.
- Undefined: these ports and their logic are absent. Consumers read the register file one cycle later.

## Structure
- Package `rf_arb_pkg`:
  - `DATA_W`, `ADDR_W`, `NUM_REGS` constants.
  - `reg_idx_t` and `reg_data_t` typedefs.
  - Write-request struct {valid, rd, data}.
- Sub-module `rr_arb2`: 2-input round-robin grant with `last_grant` state, instanced once.
- Scoreboard and output register live in the top.

## Test plan
- After reset, both requests invalid → `rf_we`=0, `sb_pending`=0, `req0_ready`=`req1_ready`=0.
- Issue rd=5, then req0 {rd=5, data=0xDEADBEEF} → `req0_ready`=1; next cycle `rf_we`=1, `rf_waddr`=5, `rf_wdata`=0xDEADBEEF; `sb_pending[5]` clears at that edge.
- Both requests valid for 4 cycles (rd=1 and rd=2) → grants alternate 0,1,0,1 and `rf_waddr` sequence is 1,2,1,2.
- req1 rd=0 data=0x1234 → `req1_ready`=1, next cycle `rf_we`=0, and `sb_pending[0]` stays 0.
- Issue rd=7 in the same cycle that rd=7 retires → `sb_pending[7]` remains 1.
- Assert `rst` low while a write to rd=9 sits in the output stage → `rf_we` drops to 0 immediately; `sb_pending`=0; after release the first tie goes to req0. With `RF_ARB_BYPASS_EN`: `rs1_addr`=9 while that write is in flight → `fwd1_hit`=1, `fwd1_data`=the staged data.

Source files
------------

// File: rtl/rf_arb_pkg.sv
// rf_arb_pkg: shared constants and types for the register-file write-back arbiter.
//   DATA_W / ADDR_W / NUM_REGS : default data width, register index width, register count.
//   reg_idx_t / reg_data_t     : register index and data types.
//   wb_req_t                   : one write-back request {valid, rd, data}.
package rf_arb_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 32;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  typedef struct packed {
    logic      valid;
    reg_idx_t  rd;
    reg_data_t data;
  } wb_req_t;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin grant with a one-bit last-grant register.
//   i_clk   : clock, rising edge.
//   i_rst_n : asynchronous active-low reset; last grant resets to 1 so input 0 wins the first tie.
//   i_req   : request vector, bit n from requester n.
//   o_gnt   : combinational one-hot (or zero) grant vector.
module rr_arb2 (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  logic r_last_grant;

  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      // On a tie the requester that did not win last time goes first.
      2'b11:   o_gnt = r_last_grant ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last_grant <= 1'b1;
    end else if (|i_req) begin
      r_last_grant <= o_gnt[1];
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register file's single write port between the ALU
// write-back (req0) and the load/mul-div write-back (req1), with a pending-write scoreboard.
//   clk, rst                    : clock and asynchronous active-low reset.
//   reqN_valid/rd/data, ready   : write-back requesters; ready is the combinational grant.
//   issue_valid, issue_rd       : marks a destination register as pending.
//   sb_pending                  : one bit per register, set while a write is outstanding.
//   rf_we, rf_waddr, rf_wdata   : registered write port into the register file.
// Optional feature, macro RF_ARB_BYPASS_EN: adds rs1_addr/rs2_addr inputs and
// fwd1_hit/fwd1_data/fwd2_hit/fwd2_data outputs forwarding the write in flight.
module regfile_wb_arbiter
  import rf_arb_pkg::*;
#(
  parameter int unsigned DATA_W   = rf_arb_pkg::DATA_W,
  parameter int unsigned ADDR_W   = rf_arb_pkg::ADDR_W,
  parameter int unsigned NUM_REGS = rf_arb_pkg::NUM_REGS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0_valid,
  input  logic [ADDR_W-1:0]   req0_rd,
  input  logic [DATA_W-1:0]   req0_data,
  output logic                req0_ready,
  input  logic                req1_valid,
  input  logic [ADDR_W-1:0]   req1_rd,
  input  logic [DATA_W-1:0]   req1_data,
  output logic                req1_ready,
  input  logic                issue_valid,
  input  logic [ADDR_W-1:0]   issue_rd,
  output logic [NUM_REGS-1:0] sb_pending,
  output logic                rf_we,
  output logic [ADDR_W-1:0]   rf_waddr,
  output logic [DATA_W-1:0]   rf_wdata
`ifdef RF_ARB_BYPASS_EN
  ,
  input  logic [ADDR_W-1:0]   rs1_addr,
  input  logic [ADDR_W-1:0]   rs2_addr,
  output logic                fwd1_hit,
  output logic [DATA_W-1:0]   fwd1_data,
  output logic                fwd2_hit,
  output logic [DATA_W-1:0]   fwd2_data
`endif
);

  wb_req_t             w_req0;
  wb_req_t             w_req1;
  wb_req_t             w_sel;
  logic [1:0]          w_gnt;
  logic                w_any_gnt;
  logic [NUM_REGS-1:0] w_sb_d;

  logic                r_rf_we;
  logic [ADDR_W-1:0]   r_rf_waddr;
  logic [DATA_W-1:0]   r_rf_wdata;
  logic [NUM_REGS-1:0] r_sb;

  assign w_req0 = '{valid: req0_valid, rd: reg_idx_t'(req0_rd), data: reg_data_t'(req0_data)};
  assign w_req1 = '{valid: req1_valid, rd: reg_idx_t'(req1_rd), data: reg_data_t'(req1_data)};

  rr_arb2 u_rr_arb2 (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_req   ({w_req1.valid, w_req0.valid}),
    .o_gnt   (w_gnt)
  );

  assign req0_ready = w_gnt[0];
  assign req1_ready = w_gnt[1];
  assign w_any_gnt  = |w_gnt;
  assign w_sel      = w_gnt[1] ? w_req1 : w_req0;

  // Output stage never stalls; an x0 write is accepted but never reaches the file.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rf_we    <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
    end else begin
      r_rf_we <= w_any_gnt && (w_sel.rd != '0);
      if (w_any_gnt && (w_sel.rd != '0)) begin
        r_rf_waddr <= ADDR_W'(w_sel.rd);
        r_rf_wdata <= DATA_W'(w_sel.data);
      end
    end
  end

  // Clear on retire, then set on issue so a newer producer on the same index stays pending.
  always_comb begin
    w_sb_d = r_sb;
    if (r_rf_we) begin
      w_sb_d[r_rf_waddr] = 1'b0;
    end
    if (issue_valid && (issue_rd != '0)) begin
      w_sb_d[issue_rd] = 1'b1;
    end
    w_sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sb <= '0;
    end else begin
      r_sb <= w_sb_d;
    end
  end

  assign sb_pending = r_sb;
  assign rf_we      = r_rf_we;
  assign rf_waddr   = r_rf_waddr;
  assign rf_wdata   = r_rf_wdata;

`ifdef RF_ARB_BYPASS_EN
  // The file's read port still returns old data during the write cycle.
  assign fwd1_hit  = r_rf_we && (r_rf_waddr == rs1_addr) && (rs1_addr != '0);
  assign fwd1_data = r_rf_wdata;
  assign fwd2_hit  = r_rf_we && (r_rf_waddr == rs2_addr) && (rs2_addr != '0);
  assign fwd2_data = r_rf_wdata;
`endif

`ifndef SYNTHESIS
  // Requesters may only write back registers that are marked pending.
  a_req0_pending: assert property (@(posedge clk) disable iff (!rst)
    (req0_valid && req0_ready && (req0_rd != '0)) |-> r_sb[req0_rd]);
  a_req1_pending: assert property (@(posedge clk) disable iff (!rst)
    (req1_valid && req1_ready && (req1_rd != '0)) |-> r_sb[req1_rd]);
`endif

endmodule
